// File: rtl/arb_mux_n.sv
// N-input arbitrated selector (fixed-priority or round-robin) feeding a one-entry output register.
// Latency: one cycle from input transfer to out_valid; inputs stall while the held output is not taken.
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N),
  parameter int RR    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] ch [N];
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  gnt;
  logic             gnt_vld;
  logic [SELW:0]    cand;
  logic             load_en;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign load_en = (!out_valid || out_ready) && !flush;

  // Search order starts at ptr in round-robin mode, at 0 otherwise; wraps mod N.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = (RR != 0) ? ({1'b0, ptr} + (SELW+1)'(k)) : (SELW+1)'(k);
      if (cand >= (SELW+1)'(N)) begin
        cand = cand - (SELW+1)'(N);
      end
      if (!gnt_vld && in_valid[cand[SELW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = cand[SELW-1:0];
      end
    end
  end

  // rst_n gating keeps in_ready quiet during reset, when load_en alone would be high.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && load_en && gnt_vld && (gnt == SELW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (load_en) begin
      if (gnt_vld) begin
        out_data  <= ch[gnt];
        out_sel   <= gnt;
        out_valid <= 1'b1;
        if (RR != 0) begin
          ptr <= (gnt == SELW'(N-1)) ? '0 : gnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else if (flush) begin
      out_valid <= 1'b0;
    end
  end

endmodule
